// File: rtl/pc_redirect_if.sv
// Branch-unit / hazard-unit / fetch-address bundle for the PC redirect controller.
// The master side is the pipeline (drives resolutions and stalls); the slave side is the controller.
interface pc_redirect_if #(
  parameter int unsigned PC_W = 9
);
  logic            Stall;
  logic            Ex_Valid;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic [PC_W-1:0] PC;
  logic            Flush_IF_ID;
  logic            Flush_ID_EX;
  logic            Redirect_Busy;
  logic            Misalign_Err;
  logic            Range_Err;
  logic [15:0]     Redirect_Count;

  modport master (
    output Stall, Ex_Valid, PcSel, BrPC,
    input  PC, Flush_IF_ID, Flush_ID_EX, Redirect_Busy,
           Misalign_Err, Range_Err, Redirect_Count
  );

  modport slave (
    input  Stall, Ex_Valid, PcSel, BrPC,
    output PC, Flush_IF_ID, Flush_ID_EX, Redirect_Busy,
           Misalign_Err, Range_Err, Redirect_Count
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner and control-flow redirect sequencer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | normal fetch; a live taken resolution is applied or parked
// PENDING | a redirect arrived under stall; target held until stall drops
// SHADOW  | redirect applied; wrong-path EX resolutions ignored while the
//         | flushed bubbles drain (SHADOW_CYC unstalled cycles)
module pc_redirect_ctrl #(
  parameter int unsigned     PC_W       = 9,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     SHADOW_CYC = 2
) (
  input  logic           clk,
  input  logic           reset,
  pc_redirect_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SHADOW  = 2'd2
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     pend_q;
  logic [1:0]      sh_cnt_q;
  logic [15:0]     redirect_count_q;
  logic            misalign_q;
  logic            range_q;

  logic            req;
  logic            apply;
  logic [31:0]     target;

  // Decide whether this cycle applies a redirect and which target it uses;
  // a live request in PENDING supersedes the parked target.
  always_comb begin
    req    = bus.Ex_Valid && bus.PcSel && (state_q != SHADOW);
    apply  = 1'b0;
    target = bus.BrPC;
    if (!bus.Stall) begin
      if (state_q == IDLE && req) apply = 1'b1;
      if (state_q == PENDING)     apply = 1'b1;
    end
    if (state_q == PENDING && !req) target = pend_q;
  end

  // PC, FSM, pending target, shadow timer, redirect counter and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      pc_q             <= RESET_PC;
      pend_q           <= '0;
      sh_cnt_q         <= '0;
      redirect_count_q <= '0;
      misalign_q       <= 1'b0;
      range_q          <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
      if (apply) begin
        // Low two bits are dropped and upper bits truncated; the error
        // pulses only report it, fetch continues at the truncated address.
        pc_q       <= {target[PC_W-1:2], 2'b00};
        state_q    <= SHADOW;
        sh_cnt_q   <= 2'(SHADOW_CYC);
        misalign_q <= |target[1:0];
        range_q    <= |target[31:PC_W];
        if (redirect_count_q != 16'hFFFF)
          redirect_count_q <= redirect_count_q + 16'd1;
      end else begin
        case (state_q)
          IDLE: begin
            if (req) begin
              pend_q  <= bus.BrPC;
              state_q <= PENDING;
            end else if (!bus.Stall) begin
              pc_q <= pc_q + PC_W'(4);
            end
          end
          PENDING: begin
            if (req) pend_q <= bus.BrPC;
          end
          SHADOW: begin
            if (!bus.Stall) begin
              pc_q     <= pc_q + PC_W'(4);
              sh_cnt_q <= sh_cnt_q - 2'd1;
              if (sh_cnt_q <= 2'd1) state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Every 1-bit output is forced low during reset, even before the first
  // reset edge has cleared the registers behind it.
  always_comb begin
    bus.PC             = pc_q;
    bus.Flush_IF_ID    = apply && !reset;
    bus.Flush_ID_EX    = apply && !reset;
    bus.Redirect_Busy  = (state_q != IDLE) && !reset;
    bus.Misalign_Err   = misalign_q && !reset;
    bus.Range_Err      = range_q && !reset;
    bus.Redirect_Count = redirect_count_q;
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed, table-driven bench for pc_redirect_ctrl (PC_W=9, RESET_PC=0, SHADOW_CYC=2).
module tb_pc_redirect_ctrl;

  logic clk;
  logic reset;

  pc_redirect_if #(.PC_W(9)) bus ();

  pc_redirect_ctrl #(
    .PC_W       (9),
    .RESET_PC   (9'h000),
    .SHADOW_CYC (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic        ev;
    logic        ps;
    logic [31:0] br;
    logic [8:0]  pc;
    logic        fl;
    logic        bz;
    logic        mi;
    logic        rg;
    logic [15:0] cnt;
  } vec_t;

  int   n_checks;
  int   n_errors;
  int   row;
  vec_t tbl[37];
  vec_t sat[8];

  function automatic vec_t mk(int rst, int st, int ev, int ps, int br,
                              int pc, int fl, int bz, int mi, int rg, int cnt);
    vec_t v;
    v.rst = rst[0];
    v.st  = st[0];
    v.ev  = ev[0];
    v.ps  = ps[0];
    v.br  = br;
    v.pc  = pc[8:0];
    v.fl  = fl[0];
    v.bz  = bz[0];
    v.mi  = mi[0];
    v.rg  = rg[0];
    v.cnt = cnt[15:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, row, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check outputs before the rising edge.
  task automatic run_vec(input vec_t v, input logic force_sat);
    @(negedge clk);
    reset        = v.rst;
    bus.Stall    = v.st;
    bus.Ex_Valid = v.ev;
    bus.PcSel    = v.ps;
    bus.BrPC     = v.br;
    if (force_sat) force dut.redirect_count_q = 16'hFFFD;
    #1;
    if (force_sat) release dut.redirect_count_q;
    chk("pc",          32'(bus.PC),             32'(v.pc));
    chk("flush_if_id", 32'(bus.Flush_IF_ID),    32'(v.fl));
    chk("flush_id_ex", 32'(bus.Flush_ID_EX),    32'(v.fl));
    chk("busy",        32'(bus.Redirect_Busy),  32'(v.bz));
    chk("misalign",    32'(bus.Misalign_Err),   32'(v.mi));
    chk("range",       32'(bus.Range_Err),      32'(v.rg));
    chk("count",       32'(bus.Redirect_Count), 32'(v.cnt));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    row      = 0;

    //            rst st ev ps br      pc     fl bz mi rg cnt
    tbl[0]  = mk(1, 0, 1, 1, 'h40,  'h000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0,     'h000, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,     'h004, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,     'h008, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,     'h00C, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 1, 1, 'h40,  'h010, 1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 1, 'h80,  'h040, 0, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 1, 'h80,  'h044, 0, 1, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0,     'h048, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 1, 1, 'h60,  'h04C, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 1, 1, 1, 'h64,  'h04C, 0, 1, 0, 0, 1);
    tbl[11] = mk(0, 1, 1, 1, 'h64,  'h04C, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 1, 'h99,  'h04C, 1, 1, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0,     'h064, 0, 1, 0, 0, 2);
    tbl[14] = mk(0, 0, 0, 0, 0,     'h068, 0, 1, 0, 0, 2);
    tbl[15] = mk(0, 0, 0, 0, 0,     'h06C, 0, 0, 0, 0, 2);
    tbl[16] = mk(0, 0, 1, 1, 'h106, 'h070, 1, 0, 0, 0, 2);
    tbl[17] = mk(0, 0, 0, 0, 0,     'h104, 0, 1, 1, 0, 3);
    tbl[18] = mk(0, 0, 0, 0, 0,     'h108, 0, 1, 0, 0, 3);
    tbl[19] = mk(0, 0, 1, 1, 'h208, 'h10C, 1, 0, 0, 0, 3);
    tbl[20] = mk(0, 0, 0, 0, 0,     'h008, 0, 1, 0, 1, 4);
    tbl[21] = mk(0, 0, 0, 0, 0,     'h00C, 0, 1, 0, 0, 4);
    tbl[22] = mk(0, 1, 1, 1, 'h20,  'h010, 0, 0, 0, 0, 4);
    tbl[23] = mk(0, 0, 1, 1, 'h30,  'h010, 1, 1, 0, 0, 4);
    tbl[24] = mk(0, 0, 0, 0, 0,     'h030, 0, 1, 0, 0, 5);
    tbl[25] = mk(0, 1, 1, 1, 'h80,  'h034, 0, 1, 0, 0, 5);
    tbl[26] = mk(0, 0, 0, 0, 0,     'h034, 0, 1, 0, 0, 5);
    tbl[27] = mk(0, 1, 1, 1, 'h1F0, 'h038, 0, 0, 0, 0, 5);
    tbl[28] = mk(0, 1, 0, 0, 0,     'h038, 0, 1, 0, 0, 5);
    tbl[29] = mk(1, 0, 1, 1, 'h100, 'h038, 0, 0, 0, 0, 5);
    tbl[30] = mk(0, 0, 0, 0, 0,     'h000, 0, 0, 0, 0, 0);
    tbl[31] = mk(0, 0, 1, 1, 'h1F4, 'h004, 1, 0, 0, 0, 0);
    tbl[32] = mk(0, 0, 0, 0, 0,     'h1F4, 0, 1, 0, 0, 1);
    tbl[33] = mk(0, 0, 0, 0, 0,     'h1F8, 0, 1, 0, 0, 1);
    tbl[34] = mk(0, 0, 0, 0, 0,     'h1FC, 0, 0, 0, 0, 1);
    tbl[35] = mk(1, 0, 1, 1, 'h40,  'h000, 0, 0, 0, 0, 1);
    tbl[36] = mk(0, 0, 0, 0, 0,     'h000, 0, 0, 0, 0, 0);

    // Counter saturation: count preset to 0xFFFD in the first cycle.
    sat[0] = mk(0, 0, 1, 1, 'h80,   'h004, 1, 0, 0, 0, 'hFFFD);
    sat[1] = mk(0, 0, 0, 0, 0,      'h080, 0, 1, 0, 0, 'hFFFE);
    sat[2] = mk(0, 0, 0, 0, 0,      'h084, 0, 1, 0, 0, 'hFFFE);
    sat[3] = mk(0, 0, 1, 1, 'h80,   'h088, 1, 0, 0, 0, 'hFFFE);
    sat[4] = mk(0, 0, 0, 0, 0,      'h080, 0, 1, 0, 0, 'hFFFF);
    sat[5] = mk(0, 0, 0, 0, 0,      'h084, 0, 1, 0, 0, 'hFFFF);
    sat[6] = mk(0, 0, 1, 1, 'h80,   'h088, 1, 0, 0, 0, 'hFFFF);
    sat[7] = mk(0, 0, 0, 0, 0,      'h080, 0, 1, 0, 0, 'hFFFF);

    reset        = 1'b1;
    bus.Stall    = 1'b0;
    bus.Ex_Valid = 1'b0;
    bus.PcSel    = 1'b0;
    bus.BrPC     = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 37; i++) begin
      row = i;
      run_vec(tbl[i], 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      row = 100 + i;
      run_vec(sat[i], i == 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Owns the fetch PC register and sequences control-flow redirects from the EX-stage branch unit.
- Decides when a taken branch, JAL or JALR target is applied, and generates the IF/ID and ID/EX flushes.
- Holds a redirect that arrives during a hazard stall, and ignores wrong-path resolutions while the flushed bubbles drain.
- Sits between the branch unit, the hazard unit and the instruction memory address port.

Parameters:
PC_W, 9, width of the fetch PC (byte address)
RESET_PC, 0, PC value loaded on reset (PC_W bits, word aligned)
SHADOW_CYC, 2, cycles after an applied redirect during which Ex_Valid is ignored (1..3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Stall  in  1  hazard-unit stall; freezes PC and blocks redirect application
Ex_Valid  in  1  EX stage holds a real instruction whose PcSel/BrPC are valid this cycle
PcSel  in  1  branch unit: 1 = taken branch, JAL or JALR
BrPC  in  32  branch unit target address
PC  out  PC_W  current fetch address
Flush_IF_ID  out  1  clear IF/ID register at next edge
Flush_ID_EX  out  1  clear ID/EX register at next edge
Redirect_Busy  out  1  a redirect is pending or the shadow window is active
Misalign_Err  out  1  one-cycle pulse: applied target had BrPC[1:0] != 0
Range_Err  out  1  one-cycle pulse: applied target had BrPC[31:PC_W] != 0
Redirect_Count  out  16  number of applied redirects, saturating

Behaviour:
- Reset (sync, highest priority, including mid-operation):
  - PC=RESET_PC, state=IDLE, pending target cleared, shadow counter=0, Redirect_Count=0.
  - All 1-bit outputs are 0 while reset is high, whatever the other inputs are.
- States: IDLE, PENDING, SHADOW.
- req = Ex_Valid && PcSel, evaluated only in IDLE or PENDING. In SHADOW, Ex_Valid/PcSel/BrPC are ignored.
- Applying a redirect in cycle T:
  - Flush_IF_ID=Flush_ID_EX=1 combinationally in cycle T.
  - At edge T+1: PC <= {BrPC[PC_W-1:2],2'b00}; Redirect_Count += 1 (holds at 16'hFFFF); shadow counter <= SHADOW_CYC; state -> SHADOW.
  - Misalign_Err and Range_Err are registered and assert in cycle T+1 for exactly one cycle. Low bits are dropped and upper bits truncated; there is no trap.
- IDLE:
  - req && !Stall: apply BrPC.
  - req && Stall: capture BrPC into the pending register, state -> PENDING, PC holds, no flush.
  - !req && !Stall: PC <= PC + 4, wraps modulo 2^PC_W.
  - Stall: PC holds.
- PENDING:
  - Stall: PC holds. A new req overwrites the pending target (latest wins).
  - !Stall: apply the target. If req is high this cycle, the live BrPC is applied; otherwise the pending target.
- SHADOW:
  - Decrement the counter each cycle when !Stall; hold it when Stall.
  - Counter reaching 0 -> IDLE, and req is evaluated again from the next cycle.
  - PC advances +4 when !Stall. No flushes.
- Redirect_Busy = (state != IDLE).
- Flush outputs are 0 in every cycle that does not apply a redirect.

Test Plan:
- Reset, then 4 cycles without req or Stall -> PC 0x000, 0x004, 0x008, 0x00C; no flush; Redirect_Count=0.
- PC=0x010, req with BrPC=0x40 and Stall=0 -> flushes high that cycle; next cycle PC=0x040, Redirect_Busy=1, Count=1. A req with BrPC=0x80 in the next 2 cycles is ignored (PC 0x044, 0x048), then the state returns to IDLE.
- req with BrPC=0x60 while Stall=1 for 3 cycles, with BrPC changed to 0x64 in the 2nd cycle -> PC frozen, no flush, state PENDING; Stall drops with Ex_Valid=0 -> flush that cycle, then PC=0x064.
- req with BrPC=0x0000_0106 -> PC=0x104; Misalign_Err=1 and Range_Err=0 for one cycle. Then BrPC=0x0000_0208 -> PC=0x008, Range_Err pulses.
- PC=0x1FC, no req -> PC wraps to 0x000. Redirect_Count preset near 16'hFFFF via repeated redirects -> saturates at 16'hFFFF.
- reset asserted in the same cycle as req, and again while in PENDING -> PC=RESET_PC next cycle, no flush, Redirect_Busy=0, pending target discarded.
